// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: samples hsync/vsync, rebuilds x/y/active, checks the sync
// stream against the configured timing and reports lock, violations and measured line/frame totals.
module vga_sync_decoder #(
    parameter int HEIGHT        = 480,
    parameter int WIDTH         = 800,
    parameter int H_FRONT_PORCH = 40,
    parameter int H_SYNC_WIDTH  = 128,
    parameter int H_BACK_PORCH  = 88,
    parameter int V_FRONT_PORCH = 11,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int V_BACK_PORCH  = 31,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        active,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_count,
    output logic [10:0] h_total_meas,
    output logic [9:0]  v_total_meas
);
    localparam int H_SYNC_START = WIDTH + H_FRONT_PORCH;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_WIDTH;
    localparam int H_LINE       = H_SYNC_END + H_BACK_PORCH;
    localparam int V_SYNC_START = HEIGHT + V_FRONT_PORCH;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_WIDTH;
    localparam int V_LINE       = V_SYNC_END + V_BACK_PORCH;

    localparam int HC_W   = $clog2(H_LINE);
    localparam int VC_W   = $clog2(V_LINE);
    localparam int HS_MAX = (2 * H_LINE > 2047) ? 2 * H_LINE : 2047;
    localparam int HS_W   = $clog2(HS_MAX + 1);
    localparam int VS_MAX = (2 * V_LINE > 1023) ? 2 * V_LINE : 1023;
    localparam int VS_W   = $clog2(VS_MAX + 1);
    localparam int CL_W   = $clog2(LOCK_FRAMES + 1);

    localparam logic [HC_W-1:0] HC_LAST   = HC_W'(H_LINE - 1);
    localparam logic [HC_W-1:0] HC_SS     = HC_W'(H_SYNC_START);
    localparam logic [HC_W-1:0] HC_SE     = HC_W'(H_SYNC_END);
    localparam logic [HC_W-1:0] HC_VIS    = HC_W'(WIDTH);
    localparam logic [VC_W-1:0] VC_LAST   = VC_W'(V_LINE - 1);
    localparam logic [VC_W-1:0] VC_SS     = VC_W'(V_SYNC_START);
    localparam logic [VC_W-1:0] VC_SE     = VC_W'(V_SYNC_END);
    localparam logic [VC_W-1:0] VC_VIS    = VC_W'(HEIGHT);
    localparam logic [HS_W-1:0] HS_SAT    = HS_W'(HS_MAX);
    localparam logic [HS_W-1:0] HS_TMO    = HS_W'(2 * H_LINE);
    localparam logic [HS_W-1:0] HS_MEAS   = HS_W'(2047);
    localparam logic [VS_W-1:0] VS_SAT    = VS_W'(VS_MAX);
    localparam logic [VS_W-1:0] VS_TMO    = VS_W'(2 * V_LINE);
    localparam logic [VS_W-1:0] VS_MEAS   = VS_W'(1023);
    localparam logic [CL_W-1:0] CL_LOCK   = CL_W'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic            hs_q, hs_d, hs_prev_q, hs_prev_d;
    logic            vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;
    logic [1:0]      state_q, state_d;
    logic [CL_W-1:0] clean_q, clean_d;
    logic            locked_q, locked_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [HS_W-1:0] h_since_q, h_since_d;
    logic [VS_W-1:0] v_since_q, v_since_d;
    logic [10:0]     h_meas_q, h_meas_d;
    logic [9:0]      v_meas_q, v_meas_d;

    logic hfall, hrise, vfall, vrise, viol;

    assign hfall = hs_prev_q & ~hs_q;
    assign hrise = ~hs_prev_q & hs_q;
    assign vfall = vs_prev_q & ~vs_q;
    assign vrise = ~vs_prev_q & vs_q;

    // Any edge off its expected position, or a missing edge for two periods, breaks tracking.
    assign viol = (state_q != ST_SEARCH) &&
                  ((hfall && hc_q != HC_SS) ||
                   (hrise && hc_q != HC_SE) ||
                   (vfall && !(vc_q == VC_SS && hc_q == '0)) ||
                   (vrise && !(vc_q == VC_SE && hc_q == '0)) ||
                   (!hfall && h_since_q >= HS_TMO) ||
                   (!vfall && v_since_q >= VS_TMO));

    always_comb begin
        // NOTE: every *_d takes its held value first so no path through this block infers a latch.
        hs_d      = hsync_in;
        hs_prev_d = hs_q;
        vs_d      = vsync_in;
        vs_prev_d = vs_q;
        hc_d      = hc_q;
        vc_d      = vc_q;
        state_d   = state_q;
        clean_d   = clean_q;
        locked_d  = locked_q;
        err_cnt_d = err_cnt_q;
        h_since_d = h_since_q;
        v_since_d = v_since_q;
        h_meas_d  = h_meas_q;
        v_meas_d  = v_meas_q;

        if (hc_q == HC_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == VC_LAST) ? '0 : vc_q + 1'b1;
        end else begin
            hc_d = hc_q + 1'b1;
        end

        if (hfall) begin
            h_meas_d  = (h_since_q > HS_MEAS) ? 11'd2047 : h_since_q[10:0];
            h_since_d = HS_W'(1);
        end else if (h_since_q != HS_SAT) begin
            h_since_d = h_since_q + 1'b1;
        end

        // Line count is the number of hsync falls seen since the last vsync fall.
        if (vfall) begin
            v_meas_d  = (v_since_q > VS_MEAS) ? 10'd1023 : v_since_q[9:0];
            v_since_d = hfall ? VS_W'(1) : '0;
        end else if (hfall && v_since_q != VS_SAT) begin
            v_since_d = v_since_q + 1'b1;
        end

        if (viol) begin
            state_d  = ST_SEARCH;
            locked_d = 1'b0;
            if (err_cnt_q != 8'hff) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    // The fall marks position (0, V_SYNC_START); the counters hold the next pixel.
                    if (vfall) begin
                        hc_d    = HC_W'(1);
                        vc_d    = VC_SS;
                        clean_d = '0;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (vfall) begin
                        clean_d = clean_q + 1'b1;
                        if (clean_q + 1'b1 == CL_LOCK) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            // NOTE: samples preset high (sync idle level) so leaving reset cannot fake a falling edge.
            hs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
            hc_q      <= '0;
            vc_q      <= '0;
            state_q   <= ST_SEARCH;
            clean_q   <= '0;
            locked_q  <= 1'b0;
            err_cnt_q <= '0;
            h_since_q <= '0;
            v_since_q <= '0;
            h_meas_q  <= '0;
            v_meas_q  <= '0;
        end else begin
            hs_q      <= hs_d;
            hs_prev_q <= hs_prev_d;
            vs_q      <= vs_d;
            vs_prev_q <= vs_prev_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            state_q   <= state_d;
            clean_q   <= clean_d;
            locked_q  <= locked_d;
            err_cnt_q <= err_cnt_d;
            h_since_q <= h_since_d;
            v_since_q <= v_since_d;
            h_meas_q  <= h_meas_d;
            v_meas_q  <= v_meas_d;
        end
    end

    assign x            = (locked_q && hc_q < HC_VIS) ? 10'(hc_q) : 10'd0;
    assign y            = (locked_q && vc_q < VC_VIS) ? 9'(vc_q) : 9'd0;
    assign active       = locked_q && (hc_q < HC_VIS) && (vc_q < VC_VIS);
    assign frame_start  = locked_q && (hc_q == '0) && (vc_q == '0);
    assign locked       = locked_q;
    assign sync_err     = viol;
    assign err_count    = err_cnt_q;
    assign h_total_meas = h_meas_q;
    assign v_total_meas = v_meas_q;

endmodule
